// File: rtl/wb_arbiter_pkg.sv
// Shared widths, defaults and state encodings for the writeback arbiter.
// Also carries the one-hot decode used by the pending-load scoreboard.
package wb_arbiter_pkg;

  localparam int OPRAND_W       = 4;
  localparam int REG_W          = 16;
  localparam int NREG           = 1 << OPRAND_W;
  localparam int LD_W           = OPRAND_W + REG_W;
  localparam int LD_DEPTH_DEF   = 2;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    WB_NORMAL = 1'b0,
    WB_FORCE  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [OPRAND_W-1:0] dst;
    logic [REG_W-1:0]    data;
  } ld_entry_t;

  function automatic logic [NREG-1:0] dec_onehot(input logic [OPRAND_W-1:0] idx,
                                                 input logic en);
    logic [NREG-1:0] v;
    v = {NREG{1'b0}};
    if (en) begin
      v[idx] = 1'b1;
    end else begin
      v = {NREG{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for returning loads; pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_full;
  logic             w_empty;

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  // A pop in the same cycle frees the slot, so a push on full is then safe.
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns onto the
// single register-file write port, with a starvation guard and load scoreboard.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int LD_DEPTH   = LD_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [OPRAND_W-1:0] alu_dst,
  input  logic [REG_W-1:0]    alu_data,
  input  logic                ld_issue,
  input  logic [OPRAND_W-1:0] ld_issue_dst,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [OPRAND_W-1:0] ld_dst,
  input  logic [REG_W-1:0]    ld_data,
  input  logic [OPRAND_W-1:0] q_a,
  input  logic [OPRAND_W-1:0] q_b,
  input  logic [OPRAND_W-1:0] q_d,
  output logic                hazard,
  output logic [OPRAND_W-1:0] cadr,
  output logic [REG_W-1:0]    c,
  output logic                rfile_we
);

  localparam int CW = $clog2(STARVE_MAX) + 1;

  wb_state_e           r_state;
  wb_state_e           w_next_state;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_next_cnt;
  logic [NREG-1:0]     r_busy;
  logic                r_we;
  logic [OPRAND_W-1:0] r_cadr;
  logic [REG_W-1:0]    r_c;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [LD_W-1:0]     w_fifo_rdata;
  ld_entry_t           w_head;
  logic                w_alu_ready;
  logic                w_wr_en;
  logic [OPRAND_W-1:0] w_wr_dst;
  logic [REG_W-1:0]    w_wr_data;
  logic [NREG-1:0]     w_set_mask;
  logic [NREG-1:0]     w_clr_mask;

  assign w_push = ld_valid && !w_full;
  assign w_head = ld_entry_t'(w_fifo_rdata);

  wb_fifo #(
    .DEPTH (LD_DEPTH),
    .WIDTH (LD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({ld_dst, ld_data}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Arbitration: the ALU wins in NORMAL; STARVE_MAX consecutive wins over a
  // waiting load force a one-cycle drain with the ALU held off.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_alu_ready  = 1'b1;
    w_pop        = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_dst     = {OPRAND_W{1'b0}};
    w_wr_data    = {REG_W{1'b0}};
    case (r_state)
      WB_NORMAL: begin
        w_alu_ready = 1'b1;
        if (alu_valid) begin
          w_wr_en   = 1'b1;
          w_wr_dst  = alu_dst;
          w_wr_data = alu_data;
          if (!w_empty) begin
            if (r_cnt == CW'(STARVE_MAX - 1)) begin
              w_next_state = WB_FORCE;
              w_next_cnt   = {CW{1'b0}};
            end else begin
              w_next_cnt = r_cnt + CW'(1);
            end
          end else begin
            w_next_cnt = {CW{1'b0}};
          end
        end else if (!w_empty) begin
          w_pop      = 1'b1;
          w_wr_en    = 1'b1;
          w_wr_dst   = w_head.dst;
          w_wr_data  = w_head.data;
          w_next_cnt = {CW{1'b0}};
        end else begin
          w_next_cnt = r_cnt;
        end
      end
      WB_FORCE: begin
        w_alu_ready  = 1'b0;
        w_pop        = !w_empty;
        w_wr_en      = !w_empty;
        w_wr_dst     = w_head.dst;
        w_wr_data    = w_head.data;
        w_next_cnt   = {CW{1'b0}};
        w_next_state = WB_NORMAL;
      end
      default: begin
        w_next_state = WB_NORMAL;
        w_next_cnt   = {CW{1'b0}};
      end
    endcase
  end

  assign w_set_mask = dec_onehot(ld_issue_dst, ld_issue);
  assign w_clr_mask = dec_onehot(w_head.dst, w_pop);

  // State, scoreboard and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WB_NORMAL;
      r_cnt   <= {CW{1'b0}};
      r_busy  <= {NREG{1'b0}};
      r_we    <= 1'b0;
      r_cadr  <= {OPRAND_W{1'b0}};
      r_c     <= {REG_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_busy  <= (r_busy & ~w_clr_mask) | w_set_mask;
      r_we    <= w_wr_en;
      if (w_wr_en) begin
        r_cadr <= w_wr_dst;
        r_c    <= w_wr_data;
      end
    end
  end

  assign alu_ready = w_alu_ready;
  assign ld_ready  = !w_full;
  assign hazard    = r_busy[q_a] | r_busy[q_b] | r_busy[q_d];
  assign cadr      = r_cadr;
  assign c         = r_c;
  assign rfile_we  = r_we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset-mid-stream sequence and
// randomized traffic checked against a queue-based reference model.
module tb_wb_arbiter;

  localparam int LD_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_issue, ld_valid, ld_ready, hazard, rfile_we;
  logic [3:0]  alu_dst, ld_issue_dst, ld_dst, q_a, q_b, q_d, cadr;
  logic [15:0] alu_data, ld_data, c;

  int n_tests = 0;
  int n_fail  = 0;

  wb_arbiter #(.LD_DEPTH(LD_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dst(ld_dst), .ld_data(ld_data),
    .q_a(q_a), .q_b(q_b), .q_d(q_d), .hazard(hazard),
    .cadr(cadr), .c(c), .rfile_we(rfile_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic av; logic [3:0] ad; logic [15:0] adat;
    logic li; logic [3:0] lid;
    logic lv; logic [3:0] ld; logic [15:0] ldat;
    logic [3:0] q;
    logic e_ar, e_lr, e_hz, e_we; logic [3:0] e_cadr; logic [15:0] e_c;
  } vec_t;

  typedef struct { logic [3:0] dst; logic [15:0] data; } ld_t;

  vec_t tbl [27];
  ld_t  mq [$];
  bit   mbusy [16];
  int   m_wins;
  bit   m_force;

  function automatic vec_t mk(logic av, logic [3:0] ad, logic [15:0] adat,
                              logic li, logic [3:0] lid,
                              logic lv, logic [3:0] ld, logic [15:0] ldat, logic [3:0] q,
                              logic ar, logic lr, logic hz,
                              logic we, logic [3:0] ca, logic [15:0] cd);
    vec_t v;
    v.av = av; v.ad = ad; v.adat = adat; v.li = li; v.lid = lid;
    v.lv = lv; v.ld = ld; v.ldat = ldat; v.q = q;
    v.e_ar = ar; v.e_lr = lr; v.e_hz = hz; v.e_we = we; v.e_cadr = ca; v.e_c = cd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ad, input logic [15:0] adat,
                       input logic li, input logic [3:0] lid,
                       input logic lv, input logic [3:0] ld, input logic [15:0] ldat,
                       input logic [3:0] qa, input logic [3:0] qb, input logic [3:0] qd);
    alu_valid = av; alu_dst = ad; alu_data = adat;
    ld_issue = li; ld_issue_dst = lid;
    ld_valid = lv; ld_dst = ld; ld_data = ldat;
    q_a = qa; q_b = qb; q_d = qd;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    m_wins  = 0;
    m_force = 1'b0;
  endtask

  initial begin
    // Directed table: ALU latency, idle drain + hazard, starvation, full FIFO, set-beats-clear.
    tbl[0]  = mk(1, 5, 16'h00AA, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 5, 16'h00AA);
    tbl[1]  = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 0, 16'h0);
    tbl[2]  = mk(0, 0, 16'h0,    1, 7, 0, 0, 16'h0,    7, 1, 1, 0, 0, 0, 16'h0);
    tbl[3]  = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    7, 1, 1, 1, 0, 0, 16'h0);
    tbl[4]  = mk(0, 0, 16'h0,    0, 0, 1, 7, 16'hBEEF, 7, 1, 1, 1, 0, 0, 16'h0);
    tbl[5]  = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    7, 1, 1, 1, 1, 7, 16'hBEEF);
    tbl[6]  = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    7, 1, 1, 0, 0, 0, 16'h0);
    tbl[7]  = mk(1, 1, 16'h0101, 0, 0, 1, 2, 16'h0002, 0, 1, 1, 0, 1, 1, 16'h0101);
    tbl[8]  = mk(1, 1, 16'h0102, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 1, 16'h0102);
    tbl[9]  = mk(1, 1, 16'h0103, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 1, 16'h0103);
    tbl[10] = mk(1, 1, 16'h0104, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 1, 16'h0104);
    tbl[11] = mk(1, 1, 16'h0105, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 1, 16'h0105);
    tbl[12] = mk(1, 1, 16'h0106, 0, 0, 0, 0, 16'h0,    0, 0, 1, 0, 1, 2, 16'h0002);
    tbl[13] = mk(1, 1, 16'h0106, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 1, 16'h0106);
    tbl[14] = mk(1, 1, 16'h0107, 0, 0, 1, 8, 16'h0808, 0, 1, 1, 0, 1, 1, 16'h0107);
    tbl[15] = mk(1, 1, 16'h0108, 0, 0, 1, 9, 16'h0909, 0, 1, 1, 0, 1, 1, 16'h0108);
    tbl[16] = mk(1, 1, 16'h0109, 0, 0, 1, 10, 16'h0A0A, 0, 1, 0, 0, 1, 1, 16'h0109);
    tbl[17] = mk(1, 1, 16'h010A, 0, 0, 0, 0, 16'h0,    0, 1, 0, 0, 1, 1, 16'h010A);
    tbl[18] = mk(1, 1, 16'h010B, 0, 0, 0, 0, 16'h0,    0, 1, 0, 0, 1, 1, 16'h010B);
    tbl[19] = mk(1, 1, 16'h010C, 0, 0, 1, 11, 16'h0B0B, 0, 0, 0, 0, 1, 8, 16'h0808);
    tbl[20] = mk(1, 1, 16'h010C, 0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 1, 16'h010C);
    tbl[21] = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 1, 9, 16'h0909);
    tbl[22] = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0, 1, 1, 0, 0, 0, 16'h0);
    tbl[23] = mk(0, 0, 16'h0,    1, 4, 0, 0, 16'h0,    4, 1, 1, 0, 0, 0, 16'h0);
    tbl[24] = mk(0, 0, 16'h0,    0, 0, 1, 4, 16'h4444, 4, 1, 1, 1, 0, 0, 16'h0);
    tbl[25] = mk(0, 0, 16'h0,    1, 4, 0, 0, 16'h0,    4, 1, 1, 1, 1, 4, 16'h4444);
    tbl[26] = mk(0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    4, 1, 1, 1, 0, 0, 16'h0);

    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("reset_we",        32'(rfile_we),  32'd0);
    chk("reset_cadr",      32'(cadr),      32'd0);
    chk("reset_c",         32'(c),         32'd0);
    chk("reset_ld_ready",  32'(ld_ready),  32'd1);
    chk("reset_alu_ready", 32'(alu_ready), 32'd1);
    chk("reset_hazard",    32'(hazard),    32'd0);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].av, tbl[i].ad, tbl[i].adat, tbl[i].li, tbl[i].lid,
            tbl[i].lv, tbl[i].ld, tbl[i].ldat, tbl[i].q, 4'd0, tbl[i].q);
      #1;
      chk($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("vec%0d_ld_ready", i),  32'(ld_ready),  32'(tbl[i].e_lr));
      chk($sformatf("vec%0d_hazard", i),    32'(hazard),    32'(tbl[i].e_hz));
      tick();
      chk($sformatf("vec%0d_we", i), 32'(rfile_we), 32'(tbl[i].e_we));
      if (tbl[i].e_we) begin
        chk($sformatf("vec%0d_cadr", i), 32'(cadr), 32'(tbl[i].e_cadr));
        chk($sformatf("vec%0d_c", i),    32'(c),    32'(tbl[i].e_c));
      end
    end

    // Reset mid-stream: a buffered load to r3 must be discarded, scoreboard cleared.
    drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd0, 16'h0, 4'd3, 4'd0, 4'd0);
    tick();
    drive(1'b1, 4'd1, 16'h1111, 1'b0, 4'd0, 1'b1, 4'd3, 16'h1234, 4'd3, 4'd0, 4'd0);
    tick();
    idle();
    q_a = 4'd3;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_we",       32'(rfile_we), 32'd0);
    chk("midrst_hazard",   32'(hazard),   32'd0);
    chk("midrst_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("midrst_no_write%0d", i), 32'(rfile_we), 32'd0);
      chk($sformatf("midrst_hazard%0d", i),   32'(hazard),   32'd0);
    end

    // Randomized traffic against the reference model.
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic av, li, lv, popped, exp_we;
      logic [3:0] ad, lid, ld, pdst, exp_cadr;
      logic [15:0] adat, ldat, exp_c;
      int pre_size;
      ld_t head;
      if (m_force && alu_valid) begin
        av = alu_valid; ad = alu_dst; adat = alu_data;
      end else begin
        av = ($urandom_range(0, 9) < 6); ad = 4'($urandom_range(0, 15)); adat = 16'($urandom);
      end
      li = ($urandom_range(0, 9) < 2); lid = 4'($urandom_range(0, 15));
      lv = ($urandom_range(0, 9) < 4); ld = 4'($urandom_range(0, 15)); ldat = 16'($urandom);
      drive(av, ad, adat, li, lid, lv, ld, ldat,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      #1;
      chk("rnd_alu_ready", 32'(alu_ready), 32'(!m_force));
      chk("rnd_ld_ready",  32'(ld_ready),  32'(mq.size() < LD_DEPTH));
      chk("rnd_hazard",    32'(hazard),    32'(mbusy[q_a] | mbusy[q_b] | mbusy[q_d]));

      pre_size = mq.size();
      popped = 1'b0; pdst = 4'd0;
      exp_we = 1'b0; exp_cadr = 4'd0; exp_c = 16'h0;
      if (m_force) begin
        if (pre_size > 0) begin
          head = mq.pop_front();
          popped = 1'b1; pdst = head.dst;
          exp_we = 1'b1; exp_cadr = head.dst; exp_c = head.data;
        end
        m_force = 1'b0;
        m_wins  = 0;
      end else if (av) begin
        exp_we = 1'b1; exp_cadr = ad; exp_c = adat;
        if (pre_size > 0) begin
          m_wins++;
          if (m_wins == STARVE_MAX) begin
            m_force = 1'b1;
            m_wins  = 0;
          end
        end else begin
          m_wins = 0;
        end
      end else if (pre_size > 0) begin
        head = mq.pop_front();
        popped = 1'b1; pdst = head.dst;
        exp_we = 1'b1; exp_cadr = head.dst; exp_c = head.data;
        m_wins = 0;
      end
      if (lv && pre_size < LD_DEPTH) begin
        head.dst = ld; head.data = ldat;
        mq.push_back(head);
      end
      if (popped) mbusy[pdst] = 1'b0;
      if (li) mbusy[lid] = 1'b1;

      tick();
      chk("rnd_we", 32'(rfile_we), 32'(exp_we));
      if (exp_we) begin
        chk("rnd_cadr", 32'(cadr), 32'(exp_cadr));
        chk("rnd_c",    32'(c),    32'(exp_c));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
